// File: rtl/tqvp_uart_bus_bridge_pkg.sv
// Shared types and constants for the UART-to-peripheral-bus debug bridge.
package tqvp_uart_bus_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WDATA,
    ST_BUS_WR,
    ST_BUS_RD,
    ST_ERR_SZ,
    ST_RESP
  } state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_WAIT,
    TX_HOLD
  } tx_phase_e;

  localparam logic [7:0] RESP_ACK         = 8'hA5;
  localparam logic [7:0] RESP_ERR_SIZE    = 8'hE1;
  localparam logic [7:0] RESP_ERR_TIMEOUT = 8'hEE;
  localparam logic [1:0] BUS_NONE         = 2'b11;

  // Bytes carried by a transfer of the given size code (00=1, 01=2, 10=4).
  function automatic logic [2:0] size_nbytes(input logic [1:0] sz);
    case (sz)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/tqvp_bridge_resp_tx.sv
// LSB-first response serialiser: loads up to four bytes and hands them to the
// UART transmitter one at a time using the tx_en/tx_busy handshake.
module tqvp_bridge_resp_tx
  import tqvp_uart_bus_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [31:0] data_i,
  input  logic [2:0]  nbytes_i,
  input  logic        tx_busy_i,
  output logic        tx_en_o,
  output logic [7:0]  tx_data_o,
  output logic        done_o
);

  tx_phase_e   phase_q;
  logic [31:0] shift_q;
  logic [2:0]  left_q;
  logic        tx_en_q;
  logic [7:0]  tx_data_q;
  logic        done_q;

  // Serialiser: HOLD skips the cycle after tx_en, when tx_busy has not risen yet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q   <= TX_IDLE;
      shift_q   <= '0;
      left_q    <= '0;
      tx_en_q   <= 1'b0;
      tx_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      tx_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (phase_q)
        TX_IDLE: begin
          if (load_i) begin
            shift_q <= data_i;
            left_q  <= nbytes_i;
            phase_q <= TX_WAIT;
          end
        end
        TX_WAIT: begin
          if (!tx_busy_i) begin
            tx_en_q   <= 1'b1;
            tx_data_q <= shift_q[7:0];
            shift_q   <= {8'h00, shift_q[31:8]};
            left_q    <= left_q - 3'd1;
            if (left_q == 3'd1) begin
              done_q  <= 1'b1;
              phase_q <= TX_IDLE;
            end else begin
              phase_q <= TX_HOLD;
            end
          end
        end
        TX_HOLD: phase_q <= TX_WAIT;
        default: phase_q <= TX_IDLE;
      endcase
    end
  end

  assign tx_en_o   = tx_en_q;
  assign tx_data_o = tx_data_q;
  assign done_o    = done_q;

endmodule

// File: rtl/tqvp_uart_bus_bridge.sv
// Debug bridge: parses UART command frames, issues one TinyQV peripheral bus
// read or write per frame and returns read data or a status byte over UART.
module tqvp_uart_bus_bridge
  import tqvp_uart_bus_bridge_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT  = 255,
  parameter int unsigned IDLE_TIMEOUT = 65535,
  parameter int unsigned CNT_W        = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_en,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  output logic [5:0]  bus_address,
  output logic [31:0] bus_wdata,
  output logic [1:0]  bus_write_n,
  output logic [1:0]  bus_read_n,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready,
  output logic        active,
  output logic        err_pulse
);

  localparam logic [CNT_W-1:0] BUS_LAST  = CNT_W'(BUS_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_TIMEOUT - 1);

  state_e           state_q;
  logic [1:0]       sz_q;
  logic             rd_q;
  logic [1:0]       idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic [5:0]       addr_q;
  logic [31:0]      wdata_q;
  logic [1:0]       write_n_q;
  logic [1:0]       read_n_q;
  logic             err_q;
  logic             load_q;
  logic [31:0]      resp_data_q;
  logic [2:0]       resp_n_q;
  logic             drop_st;
  logic             tx_done;

  // States in which an incoming byte cannot be parsed and is discarded.
  always_comb begin
    drop_st = (state_q == ST_BUS_WR) || (state_q == ST_BUS_RD) ||
              (state_q == ST_ERR_SZ) || (state_q == ST_RESP);
  end

  // Frame parser, bus sequencer and timeout counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sz_q        <= '0;
      rd_q        <= 1'b0;
      idx_q       <= '0;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      write_n_q   <= BUS_NONE;
      read_n_q    <= BUS_NONE;
      err_q       <= 1'b0;
      load_q      <= 1'b0;
      resp_data_q <= '0;
      resp_n_q    <= '0;
    end else begin
      // Dropped bytes strobe err; explicit error paths below also set it.
      err_q  <= rx_valid && drop_st;
      load_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (rx_valid) begin
            sz_q    <= rx_data[1:0];
            rd_q    <= rx_data[7];
            cnt_q   <= '0;
            state_q <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (rx_valid) begin
            addr_q <= rx_data[5:0];
            cnt_q  <= '0;
            if (sz_q == 2'b11) begin
              state_q <= ST_ERR_SZ;
            end else if (rd_q) begin
              read_n_q <= sz_q;
              state_q  <= ST_BUS_RD;
            end else begin
              wdata_q <= '0;
              idx_q   <= '0;
              state_q <= ST_WDATA;
            end
          end else if (cnt_q == IDLE_LAST) begin
            err_q   <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_WDATA: begin
          if (rx_valid) begin
            wdata_q[{idx_q, 3'b000} +: 8] <= rx_data;
            cnt_q <= '0;
            if ({1'b0, idx_q} == size_nbytes(sz_q) - 3'd1) begin
              write_n_q <= sz_q;
              state_q   <= ST_BUS_WR;
            end else begin
              idx_q <= idx_q + 2'd1;
            end
          end else if (cnt_q == IDLE_LAST) begin
            err_q   <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_BUS_WR: begin
          write_n_q   <= BUS_NONE;
          resp_data_q <= {24'h0, RESP_ACK};
          resp_n_q    <= 3'd1;
          load_q      <= 1'b1;
          state_q     <= ST_RESP;
        end
        ST_BUS_RD: begin
          if (bus_ready) begin
            read_n_q    <= BUS_NONE;
            resp_data_q <= bus_rdata;
            resp_n_q    <= size_nbytes(sz_q);
            load_q      <= 1'b1;
            state_q     <= ST_RESP;
          end else if (cnt_q == BUS_LAST) begin
            read_n_q    <= BUS_NONE;
            err_q       <= 1'b1;
            resp_data_q <= {24'h0, RESP_ERR_TIMEOUT};
            resp_n_q    <= 3'd1;
            load_q      <= 1'b1;
            state_q     <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_ERR_SZ: begin
          err_q       <= 1'b1;
          resp_data_q <= {24'h0, RESP_ERR_SIZE};
          resp_n_q    <= 3'd1;
          load_q      <= 1'b1;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          if (tx_done) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  tqvp_bridge_resp_tx u_resp_tx (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (load_q),
    .data_i    (resp_data_q),
    .nbytes_i  (resp_n_q),
    .tx_busy_i (tx_busy),
    .tx_en_o   (tx_en),
    .tx_data_o (tx_data),
    .done_o    (tx_done)
  );

  assign bus_address = addr_q;
  assign bus_wdata   = wdata_q;
  assign bus_write_n = write_n_q;
  assign bus_read_n  = read_n_q;
  assign active      = (state_q != ST_IDLE);
  assign err_pulse   = err_q;

endmodule

// File: tb/tb_tqvp_uart_bus_bridge.sv
// Directed bench for the UART bus bridge: table of frames plus hand-written
// sequences for dropped bytes, inter-byte gaps and mid-frame reset.
module tb_tqvp_uart_bus_bridge;

  logic        clk;
  logic        rst_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic [5:0]  bus_address;
  logic [31:0] bus_wdata;
  logic [1:0]  bus_write_n;
  logic [1:0]  bus_read_n;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic        active;
  logic        err_pulse;

  tqvp_uart_bus_bridge #(
    .BUS_TIMEOUT  (30),
    .IDLE_TIMEOUT (40),
    .CNT_W        (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .tx_en       (tx_en),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .bus_address (bus_address),
    .bus_wdata   (bus_wdata),
    .bus_write_n (bus_write_n),
    .bus_read_n  (bus_read_n),
    .bus_rdata   (bus_rdata),
    .bus_ready   (bus_ready),
    .active      (active),
    .err_pulse   (err_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transmitter model: busy for 4 cycles starting the cycle after tx_en.
  int busy_left = 0;
  always @(negedge clk) begin
    if (tx_en) busy_left <= 4;
    else if (busy_left > 0) busy_left <= busy_left - 1;
  end
  assign tx_busy = (busy_left != 0);

  // Peripheral model: ready once read_n has been held more than wait_cfg cycles.
  int wait_cfg;
  int rdc = 0;
  always @(negedge clk) rdc <= (bus_read_n != 2'b11) ? rdc + 1 : 0;
  assign bus_ready = (bus_read_n != 2'b11) && (rdc > wait_cfg);

  // Bus and UART monitors (cumulative counts).
  int          wr_cyc = 0, rd_cyc = 0, err_cnt = 0, both_cnt = 0, tx_cnt = 0;
  logic [5:0]  seen_addr = '0;
  logic [1:0]  seen_sz = '0;
  logic [31:0] seen_wdata = '0;
  logic [7:0]  tx_log [256];
  always @(negedge clk) begin
    if (bus_write_n != 2'b11) begin
      wr_cyc     <= wr_cyc + 1;
      seen_addr  <= bus_address;
      seen_wdata <= bus_wdata;
      seen_sz    <= bus_write_n;
    end
    if (bus_read_n != 2'b11) begin
      rd_cyc    <= rd_cyc + 1;
      seen_addr <= bus_address;
      seen_sz   <= bus_read_n;
    end
    if (bus_write_n != 2'b11 && bus_read_n != 2'b11) both_cnt <= both_cnt + 1;
    if (err_pulse) err_cnt <= err_cnt + 1;
    if (tx_en) begin
      tx_log[tx_cnt[7:0]] <= tx_data;
      tx_cnt <= tx_cnt + 1;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n = 0;
    @(negedge clk);
    while (active && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (active) check({nm, "_idle_budget"}, 32'(active), 32'd0);
  endtask

  typedef struct {
    string       name;
    int          nrx;
    logic [47:0] rx;
    int          wait_cfg;
    logic [31:0] rdata;
    int          exp_wr;
    int          exp_rd;
    logic [5:0]  exp_addr;
    logic [1:0]  exp_sz;
    logic [31:0] exp_wdata;
    int          exp_err;
    int          exp_ntx;
    logic [31:0] exp_tx;
  } vec_t;

  vec_t vecs [11];
  vec_t v;
  int wr0, rd0, err0, tx0;

  task automatic snap();
    wr0 = wr_cyc; rd0 = rd_cyc; err0 = err_cnt; tx0 = tx_cnt;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{"write8",       3, 48'h0000_0001_0C00, 0,    32'h0,        1, 0,  6'h0C, 2'b00, 32'h00000001, 0, 1, 32'h000000A5};
    vecs[1]  = '{"read32",       2, 48'h0000_0000_0882, 0,    32'hDEADBEEF, 0, 1,  6'h08, 2'b10, 32'h0,        0, 4, 32'hDEADBEEF};
    vecs[2]  = '{"read32_ws10",  2, 48'h0000_0000_0882, 10,   32'h12345678, 0, 11, 6'h08, 2'b10, 32'h0,        0, 4, 32'h12345678};
    vecs[3]  = '{"read_timeout", 2, 48'h0000_0000_1081, 1000, 32'hCAFEF00D, 0, 30, 6'h10, 2'b01, 32'h0,        1, 1, 32'h000000EE};
    vecs[4]  = '{"bad_size",     2, 48'h0000_0000_0403, 0,    32'h0,        0, 0,  6'h04, 2'b11, 32'h0,        1, 1, 32'h000000E1};
    vecs[5]  = '{"write16",      4, 48'h0000_1234_0401, 0,    32'h0,        1, 0,  6'h04, 2'b01, 32'h00001234, 0, 1, 32'h000000A5};
    vecs[6]  = '{"write32_rsvd", 6, 48'h4433_2211_FF7E, 0,    32'h0,        1, 0,  6'h3F, 2'b10, 32'h44332211, 0, 1, 32'h000000A5};
    vecs[7]  = '{"read8_ws2",    2, 48'h0000_0000_0180, 2,    32'hAABBCCDD, 0, 3,  6'h01, 2'b00, 32'h0,        0, 1, 32'h000000DD};
    vecs[8]  = '{"read16",       2, 48'h0000_0000_2A81, 0,    32'h1234BEEF, 0, 1,  6'h2A, 2'b01, 32'h0,        0, 2, 32'h0000BEEF};
    vecs[9]  = '{"idle_timeout", 3, 48'h0000_00AA_0802, 0,    32'h0,        0, 0,  6'h00, 2'b00, 32'h0,        1, 0, 32'h0};
    vecs[10] = '{"write_after",  3, 48'h0000_005A_0500, 0,    32'h0,        1, 0,  6'h05, 2'b00, 32'h0000005A, 0, 1, 32'h000000A5};

    rst_n = 1'b0; rx_valid = 1'b0; rx_data = '0; bus_rdata = '0; wait_cfg = 0;
    repeat (3) @(negedge clk);
    check("rst_tx_en",   32'(tx_en),       32'd0);
    check("rst_tx_data", 32'(tx_data),     32'd0);
    check("rst_addr",    32'(bus_address), 32'd0);
    check("rst_wdata",   bus_wdata,        32'd0);
    check("rst_write_n", 32'(bus_write_n), 32'd3);
    check("rst_read_n",  32'(bus_read_n),  32'd3);
    check("rst_active",  32'(active),      32'd0);
    check("rst_err",     32'(err_pulse),   32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      v = vecs[i];
      wait_cfg  = v.wait_cfg;
      bus_rdata = v.rdata;
      snap();
      for (int k = 0; k < v.nrx; k++) send_rx(v.rx[8*k +: 8]);
      wait_idle(v.name, 300);
      repeat (6) @(negedge clk);
      check({v.name, "_wr_cycles"}, 32'(wr_cyc - wr0),   32'(v.exp_wr));
      check({v.name, "_rd_cycles"}, 32'(rd_cyc - rd0),   32'(v.exp_rd));
      check({v.name, "_err"},       32'(err_cnt - err0), 32'(v.exp_err));
      check({v.name, "_ntx"},       32'(tx_cnt - tx0),   32'(v.exp_ntx));
      if (v.exp_wr > 0 || v.exp_rd > 0) begin
        check({v.name, "_addr"}, 32'(seen_addr), 32'(v.exp_addr));
        check({v.name, "_sz"},   32'(seen_sz),   32'(v.exp_sz));
      end
      if (v.exp_wr > 0) check({v.name, "_wdata"}, seen_wdata, v.exp_wdata);
      for (int k = 0; k < v.exp_ntx; k++)
        check($sformatf("%s_tx%0d", v.name, k), 32'(tx_log[(tx0 + k) % 256]), 32'(v.exp_tx[8*k +: 8]));
    end

    // Byte arriving during the response is dropped; response stays intact.
    wait_cfg = 0; bus_rdata = 32'h01020304;
    snap();
    send_rx(8'h82); send_rx(8'h08);
    for (int n = 0; n < 100 && tx_cnt == tx0; n++) @(negedge clk);
    check("drop_first_tx_seen", 32'(tx_cnt > tx0), 32'd1);
    send_rx(8'h00);
    wait_idle("drop", 300);
    repeat (6) @(negedge clk);
    check("drop_active", 32'(active),         32'd0);
    check("drop_err",    32'(err_cnt - err0), 32'd1);
    check("drop_wr",     32'(wr_cyc - wr0),   32'd0);
    check("drop_rd",     32'(rd_cyc - rd0),   32'd1);
    check("drop_ntx",    32'(tx_cnt - tx0),   32'd4);
    for (int k = 0; k < 4; k++)
      check($sformatf("drop_tx%0d", k), 32'(tx_log[(tx0 + k) % 256]), 32'(4 - k));

    // Inter-byte gaps shorter than the idle timeout keep the frame alive.
    snap();
    send_rx(8'h00);
    repeat (30) @(negedge clk);
    send_rx(8'h07);
    repeat (30) @(negedge clk);
    send_rx(8'h09);
    wait_idle("gap", 300);
    repeat (6) @(negedge clk);
    check("gap_wr",    32'(wr_cyc - wr0),   32'd1);
    check("gap_addr",  32'(seen_addr),      32'h07);
    check("gap_wdata", seen_wdata,          32'h00000009);
    check("gap_err",   32'(err_cnt - err0), 32'd0);
    check("gap_ntx",   32'(tx_cnt - tx0),   32'd1);

    // Asynchronous reset in the middle of the write data phase.
    snap();
    send_rx(8'h02); send_rx(8'h08); send_rx(8'h11);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mrst_active",  32'(active),      32'd0);
    check("mrst_addr",    32'(bus_address), 32'd0);
    check("mrst_wdata",   bus_wdata,        32'd0);
    check("mrst_write_n", 32'(bus_write_n), 32'd3);
    check("mrst_read_n",  32'(bus_read_n),  32'd3);
    check("mrst_tx_en",   32'(tx_en),       32'd0);
    check("mrst_tx_data", 32'(tx_data),     32'd0);
    check("mrst_err",     32'(err_pulse),   32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send_rx(8'h00); send_rx(8'h0C); send_rx(8'h01);
    wait_idle("post_rst", 300);
    repeat (6) @(negedge clk);
    check("post_rst_wr",    32'(wr_cyc - wr0),   32'd1);
    check("post_rst_wdata", seen_wdata,          32'h00000001);
    check("post_rst_ntx",   32'(tx_cnt - tx0),   32'd1);
    check("post_rst_tx0",   32'(tx_log[tx0 % 256]), 32'hA5);
    check("post_rst_err",   32'(err_cnt - err0), 32'd0);

    check("never_both_strobes", 32'(both_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
